// File: rtl/de2_115_sopc_memfill_pkg.sv
// Shared types and constants for the on-chip memory fill/verify engine.
// Build option MEMFILL_VERIFY_EN (see top) adds the read-back check path.
package de2_115_sopc_memfill_pkg;
    localparam int DEFAULT_DEPTH = 51200;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_CHECK, ST_DRAIN} state_t;

    localparam logic [2:0] CSR_CTRL      = 3'd0;
    localparam logic [2:0] CSR_BASE      = 3'd1;
    localparam logic [2:0] CSR_LENGTH    = 3'd2;
    localparam logic [2:0] CSR_PATTERN   = 3'd3;
    localparam logic [2:0] CSR_MISCOUNT  = 3'd4;
    localparam logic [2:0] CSR_FIRST_ERR = 3'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_INCR  = 2;
    localparam int CTRL_ABORT = 3;

    // Data of word idx in the range: constant or incrementing pattern.
    function automatic logic [31:0] word_data(logic [31:0] pattern, logic incr, logic [16:0] idx);
        return incr ? pattern + {15'd0, idx} : pattern;
    endfunction
endpackage

// File: rtl/de2_115_sopc_memfill_addr_gen.sv
// Loadable word counter: modulo-DEPTH address, word index and last-word flag.
module de2_115_sopc_memfill_addr_gen
    import de2_115_sopc_memfill_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [16:0]   length,
    output logic [AW-1:0] addr,
    output logic [16:0]   idx,
    output logic          last
);
    logic [16:0] len_m1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr   <= '0;
            idx    <= '0;
            len_m1 <= '0;
        end else if (load) begin
            addr   <= base;
            idx    <= '0;
            len_m1 <= length - 17'd1;
        end else if (step) begin
            addr <= (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
            idx  <= idx + 17'd1;
        end
    end

    assign last = (idx == len_m1);
endmodule

// File: rtl/de2_115_sopc_memfill.sv
// Avalon-MM fill/verify engine driving the on-chip RAM port while busy.
// Define MEMFILL_VERIFY_EN to build the CHECK/DRAIN read-back compare path.
module de2_115_sopc_memfill
    import de2_115_sopc_memfill_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    csr_address,
    input  logic          csr_read,
    input  logic          csr_write,
    input  logic [31:0]   csr_writedata,
    output logic [31:0]   csr_readdata,
    input  logic          hold,
    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic          mem_clken,
    input  logic [31:0]   mem_readdata,
    output logic          busy,
    output logic          irq
);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t        state;
    logic [AW-1:0] base_r;
    logic [16:0]   len_r;
    logic [31:0]   pat_r;
    logic          incr_r, done, err, aborted;
    logic          en, run, ctrl_wr, start_req, abort_req, bad_range, mode_bad;
    logic [AW-1:0] ag_addr;
    logic [16:0]   ag_idx;
    logic          ag_last;
    logic [31:0]   rd_mux;

`ifdef MEMFILL_VERIFY_EN
    logic [16:0]   miscount;
    logic [AW-1:0] first_err;
    logic          cmp_vld, mismatch;
    logic [31:0]   cmp_exp;
    logic [AW-1:0] cmp_addr;
    assign mismatch = cmp_vld && en && (mem_readdata != cmp_exp);
    assign mode_bad = 1'b0;
`else
    logic unused_rd;
    assign unused_rd = ^mem_readdata;
    assign mode_bad  = csr_writedata[CTRL_MODE];
`endif

    assign busy           = (state != ST_IDLE);
    assign en             = busy & ~hold;
    assign run            = (state == ST_FILL) || (state == ST_CHECK);
    assign mem_clken      = en;
    assign mem_byteenable = busy ? 4'hF : 4'h0;
    assign mem_chipselect = run;
    assign mem_write      = (state == ST_FILL);
    assign mem_address    = ag_addr;
    assign mem_writedata  = (state == ST_FILL) ? word_data(pat_r, incr_r, ag_idx) : '0;
    assign irq            = done | err;

    // ABORT only matters while busy, START only while idle.
    assign ctrl_wr   = csr_write && (csr_address == CSR_CTRL);
    assign abort_req = ctrl_wr && csr_writedata[CTRL_ABORT] && busy;
    assign start_req = ctrl_wr && csr_writedata[CTRL_START] && !busy;
    assign bad_range = (32'(base_r) >= DEPTH_W) || (32'(len_r) > DEPTH_W);

    de2_115_sopc_memfill_addr_gen #(.DEPTH(DEPTH), .AW(AW)) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (start_req),
        .step   (en && run),
        .base   (base_r),
        .length (len_r),
        .addr   (ag_addr),
        .idx    (ag_idx),
        .last   (ag_last)
    );

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            CSR_CTRL:      rd_mux = {28'd0, aborted, err, done, busy};
            CSR_BASE:      rd_mux = 32'(base_r);
            CSR_LENGTH:    rd_mux = 32'(len_r);
            CSR_PATTERN:   rd_mux = pat_r;
`ifdef MEMFILL_VERIFY_EN
            CSR_MISCOUNT:  rd_mux = 32'(miscount);
            CSR_FIRST_ERR: rd_mux = 32'(first_err);
`endif
            default:       ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            base_r       <= '0;
            len_r        <= '0;
            pat_r        <= '0;
            incr_r       <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            aborted      <= 1'b0;
            csr_readdata <= '0;
`ifdef MEMFILL_VERIFY_EN
            miscount     <= '0;
            first_err    <= '1;
            cmp_vld      <= 1'b0;
            cmp_exp      <= '0;
            cmp_addr     <= '0;
`endif
        end else begin
            if (csr_write && !busy) begin
                case (csr_address)
                    CSR_BASE:    base_r <= csr_writedata[AW-1:0];
                    CSR_LENGTH:  len_r  <= csr_writedata[16:0];
                    CSR_PATTERN: pat_r  <= csr_writedata;
                    default:     ;
                endcase
            end
            if (csr_read)
                csr_readdata <= rd_mux;

            if (abort_req) begin
                state   <= ST_IDLE;
                aborted <= 1'b1;
`ifdef MEMFILL_VERIFY_EN
                cmp_vld <= 1'b0;
`endif
            end else if (start_req) begin
                done    <= 1'b0;
                err     <= 1'b0;
                aborted <= 1'b0;
                incr_r  <= csr_writedata[CTRL_INCR];
`ifdef MEMFILL_VERIFY_EN
                miscount  <= '0;
                first_err <= '1;
                cmp_vld   <= 1'b0;
`endif
                if (bad_range || mode_bad)
                    err <= 1'b1;
                else if (len_r == 17'd0)
                    done <= 1'b1;
                else
                    state <= csr_writedata[CTRL_MODE] ? ST_CHECK : ST_FILL;
            end else if (en) begin
                case (state)
                    ST_FILL: if (ag_last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
`ifdef MEMFILL_VERIFY_EN
                    ST_CHECK: begin
                        cmp_vld  <= 1'b1;
                        cmp_exp  <= word_data(pat_r, incr_r, ag_idx);
                        cmp_addr <= ag_addr;
                        if (ag_last) state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        state   <= ST_IDLE;
                        done    <= 1'b1;
                        cmp_vld <= 1'b0;
                        err     <= (miscount != 17'd0) || mismatch;
                    end
`endif
                    default: ;
                endcase
`ifdef MEMFILL_VERIFY_EN
                // Compare of the word read on the previous enabled cycle.
                if (mismatch) begin
                    miscount <= miscount + 17'd1;
                    if (miscount == 17'd0) first_err <= cmp_addr;
                end
`endif
            end
        end
    end
endmodule
